// File: rtl/saturate_pkg.sv
// Shared constants and types for the saturate_u8 clamp stage.
package saturate_pkg;

  // Default widths: 10-bit brightness product narrowed to an 8-bit channel.
  localparam int unsigned SAT_IN_W  = 10;
  localparam int unsigned SAT_OUT_W = 8;
  localparam int unsigned SAT_CNT_W = 16;

  // One colour channel of the 24-bit RGB stream.
  typedef logic [SAT_OUT_W-1:0] pixel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for clamp statistics.
// It sticks at all ones instead of wrapping. clr takes priority over inc, and rst
// takes priority over both.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/saturate_u8.sv
// Unsigned clamp stage. It narrows an IN_W-bit value to OUT_W bits and registers the result.
// When the SATURATE_STATS_EN macro is defined, the build adds a saturation-event counter
// with the sat_count and cnt_clr ports.
module saturate_u8
  import saturate_pkg::*;
#(
  parameter int unsigned IN_W  = SAT_IN_W,
  parameter int unsigned OUT_W = SAT_OUT_W
`ifdef SATURATE_STATS_EN
  ,
  parameter int unsigned CNT_W = SAT_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
`ifdef SATURATE_STATS_EN
  output logic [CNT_W-1:0] sat_count,
  input  logic             cnt_clr,
`endif
  output logic             sat
);

  if (IN_W < OUT_W) begin : g_bad_width
    $error("saturate_u8: IN_W must be >= OUT_W");
  end

  logic [OUT_W-1:0] result;
  logic             sat_n;

  if (IN_W > OUT_W) begin : g_clamp
    // Any set bit above the output width means the value exceeds the ceiling.
    always_comb begin
      sat_n  = |in_data[IN_W-1:OUT_W];
      result = sat_n ? {OUT_W{1'b1}} : in_data[OUT_W-1:0];
    end
  end else begin : g_pass
    // Equal widths: nothing can overflow.
    always_comb begin
      sat_n  = 1'b0;
      result = in_data[OUT_W-1:0];
    end
  end

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             sat_q;

  // Output registers. Data and the sat flag only load on valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= result;
        sat_q      <= sat_n;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

`ifdef SATURATE_STATS_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (in_valid & sat_n),
    .count (sat_count)
  );
`endif

endmodule

// File: tb/tb_saturate_u8.sv
// Self-checking bench for saturate_u8: a reference model plus directed literal checks.
module tb_saturate_u8;

  localparam int unsigned IN_W  = 10;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CEIL  = 255;
  localparam int unsigned CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             sat;
  logic             cnt_clr;
  logic [CNT_W-1:0] sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  saturate_u8 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
`ifdef SATURATE_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef SATURATE_STATS_EN
    .sat_count (sat_count),
    .cnt_clr   (cnt_clr),
`endif
    .sat       (sat)
  );

`ifndef SATURATE_STATS_EN
  assign sat_count = '0;
`endif

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model states the behaviour directly: clamp to the ceiling, hold data while idle,
  // and keep a counter that sticks at its maximum.
  int unsigned m_data, m_sat, m_valid, m_cnt;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_data  <= 0;
      m_sat   <= 0;
      m_valid <= 0;
      m_cnt   <= 0;
    end else begin
      m_valid <= int'(in_valid);
      if (in_valid) begin
        m_data <= (int'(in_data) > CEIL) ? CEIL : int'(in_data);
        m_sat  <= (int'(in_data) > CEIL) ? 1 : 0;
      end
      if (cnt_clr) m_cnt <= 0;
      else if (in_valid && int'(in_data) > CEIL && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
    model_live <= 1'b1;
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("model_out_valid", int'(out_valid), m_valid);
      check("model_out_data", int'(out_data), m_data);
      check("model_sat", int'(sat), m_sat);
`ifdef SATURATE_STATS_EN
      check("model_sat_count", int'(sat_count), m_cnt);
`endif
    end
  end

  // Drive one cycle at the falling edge, then settle just past the next rising edge.
  task automatic step(input logic r, input logic v, input int unsigned d, input logic c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = IN_W'(d);
    cnt_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int unsigned v, input int unsigned d,
                            input int unsigned s);
    check({name, "_valid"}, int'(out_valid), v);
    check({name, "_data"}, int'(out_data), d);
    check({name, "_sat"}, int'(sat), s);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cnt_clr = 1'b0;
    @(posedge clk);
    step(1'b1, 1'b1, 1023, 1'b0);
    expect_out("reset", 0, 0, 0);
    check("reset_count", int'(sat_count), 0);

    step(1'b0, 1'b1, 100, 1'b0);  expect_out("pass100", 1, 100, 0);
    step(1'b0, 1'b1, 255, 1'b0);  expect_out("edge255", 1, 255, 0);
    step(1'b0, 1'b1, 256, 1'b0);  expect_out("edge256", 1, 255, 1);
    step(1'b0, 1'b1, 478, 1'b0);  expect_out("ovf478", 1, 255, 1);
    step(1'b0, 1'b1, 1023, 1'b0); expect_out("ovf1023", 1, 255, 1);
    step(1'b0, 1'b0, 5, 1'b0);    expect_out("hold_sat", 0, 255, 1);
    step(1'b0, 1'b1, 0, 1'b0);    expect_out("zero", 1, 0, 0);
    step(1'b0, 1'b1, 42, 1'b0);   expect_out("load42", 1, 42, 0);
    step(1'b0, 1'b0, 900, 1'b0);  expect_out("hold42", 0, 42, 0);
    step(1'b0, 1'b1, 511, 1'b0);  expect_out("ovf511", 1, 255, 1);
    step(1'b1, 1'b1, 700, 1'b0);  expect_out("rst_mid", 0, 0, 0);
    step(1'b0, 1'b1, 200, 1'b0);  expect_out("resume200", 1, 200, 0);
    step(1'b0, 1'b1, 128, 1'b0);  expect_out("pass128", 1, 128, 0);

`ifdef SATURATE_STATS_EN
    step(1'b1, 1'b0, 0, 1'b0);
    check("stats_reset", int'(sat_count), 0);
    step(1'b0, 1'b1, 1023, 1'b0); check("stats_1", int'(sat_count), 1);
    step(1'b0, 1'b1, 256, 1'b0);  check("stats_2", int'(sat_count), 2);
    step(1'b0, 1'b1, 300, 1'b0);  check("stats_3", int'(sat_count), 3);
    step(1'b0, 1'b1, 478, 1'b0);  check("stats_4", int'(sat_count), 3);
    step(1'b0, 1'b1, 999, 1'b0);  check("stats_5", int'(sat_count), 3);
    step(1'b0, 1'b1, 1023, 1'b1); check("stats_clr", int'(sat_count), 0);
    step(1'b0, 1'b1, 255, 1'b0);  check("stats_nosat", int'(sat_count), 0);
    step(1'b0, 1'b0, 1023, 1'b0); check("stats_invalid", int'(sat_count), 0);
    step(1'b0, 1'b1, 600, 1'b0);  check("stats_again", int'(sat_count), 1);
    step(1'b1, 1'b1, 1023, 1'b1); check("stats_rst_wins", int'(sat_count), 0);
`endif

    step(1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
